// File: rtl/paper_timing_pkg.sv
// Shared types, reset timing and config legality check for the paper video timing path.
// Fields are TimingW wide; sums are checked stage by stage at TimingW+1 bits.
package paper_timing_pkg;

    localparam int TimingW = 12;

    typedef struct packed {
        logic [TimingW-1:0] h_active;
        logic [TimingW-1:0] h_fp;
        logic [TimingW-1:0] h_sync;
        logic [TimingW-1:0] h_bp;
        logic [TimingW-1:0] v_active;
        logic [TimingW-1:0] v_fp;
        logic [TimingW-1:0] v_sync;
        logic [TimingW-1:0] v_bp;
        logic               hsync_pol;
        logic               vsync_pol;
    } timing_cfg_t;

    localparam timing_cfg_t TimingCfgDefault = '{
        h_active:  TimingW'(640),
        h_fp:      TimingW'(16),
        h_sync:    TimingW'(96),
        h_bp:      TimingW'(48),
        v_active:  TimingW'(480),
        v_fp:      TimingW'(10),
        v_sync:    TimingW'(2),
        v_bp:      TimingW'(33),
        hsync_pol: 1'b0,
        vsync_pol: 1'b0
    };

    function automatic logic axis_fits(
        input logic [TimingW-1:0] a,
        input logic [TimingW-1:0] b,
        input logic [TimingW-1:0] c,
        input logic [TimingW-1:0] d
    );
        logic [TimingW:0] s;
        logic             ovf;
        s   = {1'b0, a} + {1'b0, b};
        ovf = s[TimingW];
        s   = {1'b0, s[TimingW-1:0]} + {1'b0, c};
        ovf = ovf | s[TimingW];
        s   = {1'b0, s[TimingW-1:0]} + {1'b0, d};
        ovf = ovf | s[TimingW];
        return !ovf;
    endfunction

    function automatic logic cfg_legal(input timing_cfg_t c);
        return (c.h_active != '0) && (c.h_sync != '0) &&
               (c.v_active != '0) && (c.v_sync != '0) &&
               axis_fits(c.h_active, c.h_fp, c.h_sync, c.h_bp) &&
               axis_fits(c.v_active, c.v_fp, c.v_sync, c.v_bp);
    endfunction

endpackage

// File: rtl/paper_timing_axis.sv
// One timing axis: last-position detect on the current count, plus the
// advanced count and its active/sync decode.
module paper_timing_axis
    import paper_timing_pkg::*;
#(
    parameter int CntWidth = TimingW
) (
    input  logic [CntWidth-1:0] cnt,
    input  logic [CntWidth-1:0] len_active,
    input  logic [CntWidth-1:0] len_fp,
    input  logic [CntWidth-1:0] len_sync,
    input  logic [CntWidth-1:0] len_bp,
    input  logic                adv,
    output logic [CntWidth-1:0] nxt,
    output logic                last,
    output logic                active,
    output logic                sync
);

    logic [CntWidth:0] sync_start;
    logic [CntWidth:0] sync_end;
    logic [CntWidth:0] total;
    logic [CntWidth:0] cnt_inc;
    logic [CntWidth:0] nxt_ext;

    always_comb begin
        sync_start = {1'b0, len_active} + {1'b0, len_fp};
        sync_end   = sync_start + {1'b0, len_sync};
        total      = sync_end + {1'b0, len_bp};
        cnt_inc    = {1'b0, cnt} + {{CntWidth{1'b0}}, 1'b1};
        // >= keeps a stray count from running away past the end
        last       = cnt_inc >= total;
        nxt        = cnt;
        if (adv) begin
            nxt = last ? '0 : cnt_inc[CntWidth-1:0];
        end
        nxt_ext = {1'b0, nxt};
        active  = nxt_ext < {1'b0, len_active};
        sync    = (nxt_ext >= sync_start) && (nxt_ext < sync_end);
    end

endmodule

// File: rtl/paper_timing_ctrl.sv
// Video timing controller: registered DE/syncs/coordinates, shadowed config
// applied at frame wrap (or at once when idle), pixel FIFO pop and underflow.
module paper_timing_ctrl
    import paper_timing_pkg::*;
#(
    parameter int CntWidth = TimingW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                cfg_we_i,
    input  timing_cfg_t         cfg_i,
    output logic                cfg_err_o,
    output logic                cfg_pending_o,
    input  logic                px_valid_i,
    output logic                px_ready_o,
    output logic                de_o,
    output logic                hsync_o,
    output logic                vsync_o,
    output logic [CntWidth-1:0] x_o,
    output logic [CntWidth-1:0] y_o,
    output logic                line_start_o,
    output logic                frame_start_o,
    output logic                underflow_o,
    input  logic                underflow_clr_i
);

    timing_cfg_t         cfg_q;
    timing_cfg_t         pend_q;
    timing_cfg_t         cfg_next;
    logic                run_q;
    logic                h_adv, v_adv, wrap, wr_ok, apply;
    logic [CntWidth-1:0] h_nxt, v_nxt, x_n, y_n;
    logic                h_last, v_last, h_act, v_act, h_syn, v_syn;
    logic                de_n, hs_n, vs_n, line_n, frame_n;

    paper_timing_axis #(.CntWidth(CntWidth)) u_h_axis (
        .cnt       (x_o),
        .len_active(cfg_q.h_active),
        .len_fp    (cfg_q.h_fp),
        .len_sync  (cfg_q.h_sync),
        .len_bp    (cfg_q.h_bp),
        .adv       (h_adv),
        .nxt       (h_nxt),
        .last      (h_last),
        .active    (h_act),
        .sync      (h_syn)
    );

    paper_timing_axis #(.CntWidth(CntWidth)) u_v_axis (
        .cnt       (y_o),
        .len_active(cfg_q.v_active),
        .len_fp    (cfg_q.v_fp),
        .len_sync  (cfg_q.v_sync),
        .len_bp    (cfg_q.v_bp),
        .adv       (v_adv),
        .nxt       (v_nxt),
        .last      (v_last),
        .active    (v_act),
        .sync      (v_syn)
    );

    // Idle counters sit at 0, so holding them restarts the frame at (0,0).
    // Pixel (0,0) decodes the same under any legal config, so only the
    // polarity has to come from the freshly applied set.
    always_comb begin
        h_adv    = run_q;
        v_adv    = run_q & h_last;
        wrap     = run_q & h_last & v_last;
        wr_ok    = cfg_we_i & cfg_legal(cfg_i);
        apply    = cfg_pending_o & (~enable_i | ~run_q | wrap);
        cfg_next = apply ? pend_q : cfg_q;
        x_n      = '0;
        y_n      = '0;
        de_n     = 1'b0;
        hs_n     = ~cfg_next.hsync_pol;
        vs_n     = ~cfg_next.vsync_pol;
        line_n   = 1'b0;
        frame_n  = 1'b0;
        if (enable_i) begin
            x_n     = h_nxt;
            y_n     = v_nxt;
            de_n    = h_act & v_act;
            line_n  = (h_nxt == '0);
            frame_n = (h_nxt == '0) && (v_nxt == '0);
            if (h_syn) hs_n = cfg_next.hsync_pol;
            if (v_syn) vs_n = cfg_next.vsync_pol;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_q         <= TimingCfgDefault;
            pend_q        <= TimingCfgDefault;
            cfg_pending_o <= 1'b0;
            cfg_err_o     <= 1'b0;
            run_q         <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            de_o          <= 1'b0;
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            line_start_o  <= 1'b0;
            frame_start_o <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            cfg_q <= cfg_next;
            if (wr_ok) pend_q <= cfg_i;
            cfg_pending_o <= wr_ok | (cfg_pending_o & ~apply);
            cfg_err_o     <= cfg_we_i & ~wr_ok;
            run_q         <= enable_i;
            x_o           <= x_n;
            y_o           <= y_n;
            de_o          <= de_n;
            hsync_o       <= hs_n;
            vsync_o       <= vs_n;
            line_start_o  <= line_n;
            frame_start_o <= frame_n;
            underflow_o   <= (de_o & ~px_valid_i) |
                             (underflow_o & ~underflow_clr_i);
        end
    end

    assign px_ready_o = de_o;

endmodule

// File: tb/tb_paper_timing_ctrl.sv
// Directed bench for paper_timing_ctrl: default line timing, shadow config
// apply/reject, wrap collision, underflow, enable drop and mid-frame reset.
module tb_paper_timing_ctrl;
    import paper_timing_pkg::*;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               enable_i = 1'b0;
    logic               cfg_we_i = 1'b0;
    timing_cfg_t        cfg_i = TimingCfgDefault;
    logic               cfg_err_o, cfg_pending_o;
    logic               px_valid_i = 1'b1;
    logic               px_ready_o, de_o, hsync_o, vsync_o;
    logic [TimingW-1:0] x_o, y_o;
    logic               line_start_o, frame_start_o, underflow_o;
    logic               underflow_clr_i = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    paper_timing_ctrl #(.CntWidth(TimingW)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .cfg_we_i       (cfg_we_i),
        .cfg_i          (cfg_i),
        .cfg_err_o      (cfg_err_o),
        .cfg_pending_o  (cfg_pending_o),
        .px_valid_i     (px_valid_i),
        .px_ready_o     (px_ready_o),
        .de_o           (de_o),
        .hsync_o        (hsync_o),
        .vsync_o        (vsync_o),
        .x_o            (x_o),
        .y_o            (y_o),
        .line_start_o   (line_start_o),
        .frame_start_o  (frame_start_o),
        .underflow_o    (underflow_o),
        .underflow_clr_i(underflow_clr_i)
    );

    function automatic timing_cfg_t mk_cfg(
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input logic hp, input logic vp
    );
        timing_cfg_t c;
        c.h_active  = TimingW'(ha);
        c.h_fp      = TimingW'(hf);
        c.h_sync    = TimingW'(hs);
        c.h_bp      = TimingW'(hb);
        c.v_active  = TimingW'(va);
        c.v_fp      = TimingW'(vf);
        c.v_sync    = TimingW'(vs);
        c.v_bp      = TimingW'(vb);
        c.hsync_pol = hp;
        c.vsync_pol = vp;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_idle(input timing_cfg_t c);
        enable_i = 1'b0;
        tick();
        cfg_i    = c;
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_i      = 1'b1;
        enable_i   = 1'b1;
        px_valid_i = 1'b1;
        tick();
        tick();
        n_checks++;
        if (int'(x_o) != 0 || int'(y_o) != 0) begin
            n_fail++;
            $display("FAIL reset_xy: got (%0d,%0d) expected (0,0)", x_o, y_o);
        end
        n_checks++;
        if (de_o !== 1'b0 || px_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_de: got de=%b rdy=%b expected 0", de_o, px_ready_o);
        end
        n_checks++;
        if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_sync: got hs=%b vs=%b expected 1,1", hsync_o, vsync_o);
        end
        n_checks++;
        if (line_start_o !== 1'b0 || frame_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: got ls=%b fs=%b expected 0,0",
                     line_start_o, frame_start_o);
        end
        n_checks++;
        if (cfg_pending_o !== 1'b0 || cfg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cfg: got pend=%b err=%b expected 0,0",
                     cfg_pending_o, cfg_err_o);
        end
        n_checks++;
        if (underflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_uf: got %b expected 0", underflow_o);
        end
    endtask

    task automatic test_default_line();
        int xbad = 0, de_cnt = 0, de_last = -1;
        int hs_cnt = 0, hs_first = -1, hs_last = -1, vs_low = 0;
        rst_i = 1'b0;
        tick();
        n_checks++;
        if (frame_start_o !== 1'b1 || de_o !== 1'b1 || int'(x_o) != 0 || int'(y_o) != 0) begin
            n_fail++;
            $display("FAIL first_pixel: got fs=%b de=%b (%0d,%0d) expected fs=1 de=1 (0,0)",
                     frame_start_o, de_o, x_o, y_o);
        end
        for (int i = 0; i < 800; i++) begin
            if (int'(x_o) != i || int'(y_o) != 0) xbad++;
            if (de_o === 1'b1) begin
                de_cnt++;
                de_last = int'(x_o);
            end
            if (hsync_o === 1'b0) begin
                if (hs_first < 0) hs_first = int'(x_o);
                hs_last = int'(x_o);
                hs_cnt++;
            end
            if (vsync_o !== 1'b1) vs_low++;
            tick();
        end
        n_checks++;
        if (xbad != 0) begin
            n_fail++;
            $display("FAIL x_track: got %0d bad cycles expected 0", xbad);
        end
        n_checks++;
        if (de_cnt != 640 || de_last != 639) begin
            n_fail++;
            $display("FAIL default_de: got cnt=%0d last=%0d expected 640,639", de_cnt, de_last);
        end
        n_checks++;
        if (hs_cnt != 96 || hs_first != 656 || hs_last != 751) begin
            n_fail++;
            $display("FAIL default_hsync: got n=%0d %0d..%0d expected 96 656..751",
                     hs_cnt, hs_first, hs_last);
        end
        n_checks++;
        if (vs_low != 0) begin
            n_fail++;
            $display("FAIL default_vsync_line0: got %0d low cycles expected 0", vs_low);
        end
        n_checks++;
        if (line_start_o !== 1'b1 || frame_start_o !== 1'b0 || int'(x_o) != 0 || int'(y_o) != 1) begin
            n_fail++;
            $display("FAIL default_line1: got ls=%b fs=%b (%0d,%0d) expected 1,0 (0,1)",
                     line_start_o, frame_start_o, x_o, y_o);
        end
    endtask

    task automatic test_small_frame();
        int de_cnt = 0, vs_cnt = 0, vs_first = -1, hs_cnt = 0, fs_mid = 0;
        enable_i = 1'b0;
        tick();
        n_checks++;
        if (de_o !== 1'b0 || int'(x_o) != 0 || int'(y_o) != 0 || hsync_o !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_out: got de=%b (%0d,%0d) hs=%b expected 0 (0,0) 1",
                     de_o, x_o, y_o, hsync_o);
        end
        cfg_i    = mk_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_checks++;
        if (cfg_pending_o !== 1'b1 || cfg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_write: got pend=%b err=%b expected 1,0", cfg_pending_o, cfg_err_o);
        end
        tick();
        n_checks++;
        if (cfg_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_apply: got pend=%b expected 0", cfg_pending_o);
        end
        enable_i = 1'b1;
        tick();
        for (int i = 0; i < 128; i++) begin
            if (i > 0 && frame_start_o === 1'b1) fs_mid++;
            if (de_o === 1'b1) de_cnt++;
            if (hsync_o === 1'b0) hs_cnt++;
            if (vsync_o === 1'b0) begin
                if (vs_first < 0) vs_first = int'(y_o) * 16 + int'(x_o);
                vs_cnt++;
            end
            tick();
        end
        n_checks++;
        if (frame_start_o !== 1'b1 || fs_mid != 0) begin
            n_fail++;
            $display("FAIL frame_period: got fs=%b mid=%0d expected 1,0 at 128", frame_start_o, fs_mid);
        end
        n_checks++;
        if (de_cnt != 32 || hs_cnt != 24) begin
            n_fail++;
            $display("FAIL small_de_hs: got de=%0d hs=%0d expected 32,24", de_cnt, hs_cnt);
        end
        n_checks++;
        if (vs_cnt != 32 || vs_first != 80) begin
            n_fail++;
            $display("FAIL small_vsync: got n=%0d first=%0d expected 32,80", vs_cnt, vs_first);
        end
    endtask

    task automatic test_pending_apply();
        int steps = 0, pl = 0, lx = -1, ly = -1, n = 0;
        int hs_cnt = 0, hs_first = -1, hs_last = -1, de_cnt = 0;
        repeat (40) tick();
        cfg_i    = mk_cfg(1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_checks++;
        if (cfg_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_set: got %b expected 1", cfg_pending_o);
        end
        while (frame_start_o !== 1'b1 && steps < 200) begin
            if (cfg_pending_o !== 1'b1) pl++;
            lx = int'(x_o);
            ly = int'(y_o);
            tick();
            steps++;
        end
        n_checks++;
        if (steps != 87 || pl != 0) begin
            n_fail++;
            $display("FAIL pend_hold: got steps=%0d lowcyc=%0d expected 87,0", steps, pl);
        end
        n_checks++;
        if (lx != 15 || ly != 7) begin
            n_fail++;
            $display("FAIL old_last_px: got (%0d,%0d) expected (15,7)", lx, ly);
        end
        n_checks++;
        if (cfg_pending_o !== 1'b0 || hsync_o !== 1'b0 || vsync_o !== 1'b0 || de_o !== 1'b1) begin
            n_fail++;
            $display("FAIL apply_px0: got pend=%b hs=%b vs=%b de=%b expected 0,0,0,1",
                     cfg_pending_o, hsync_o, vsync_o, de_o);
        end
        do begin
            if (de_o === 1'b1) de_cnt++;
            if (hsync_o === 1'b1) begin
                if (hs_first < 0) hs_first = int'(x_o);
                hs_last = int'(x_o);
                hs_cnt++;
            end
            tick();
            n++;
        end while (line_start_o !== 1'b1 && n < 2000);
        n_checks++;
        if (n != 1650 || de_cnt != 1280) begin
            n_fail++;
            $display("FAIL hd_line: got len=%0d de=%0d expected 1650,1280", n, de_cnt);
        end
        n_checks++;
        if (hs_cnt != 40 || hs_first != 1390 || hs_last != 1429) begin
            n_fail++;
            $display("FAIL hd_hsync: got n=%0d %0d..%0d expected 40 1390..1429",
                     hs_cnt, hs_first, hs_last);
        end
    endtask

    task automatic test_reject();
        int n = 0;
        cfg_i    = mk_cfg(1280, 110, 0, 220, 720, 5, 5, 20, 1'b1, 1'b1);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_checks++;
        if (cfg_err_o !== 1'b1 || cfg_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_sync0: got err=%b pend=%b expected 1,0", cfg_err_o, cfg_pending_o);
        end
        tick();
        n_checks++;
        if (cfg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_pulse: got err=%b expected 0", cfg_err_o);
        end
        cfg_i    = mk_cfg(4000, 110, 40, 200, 720, 5, 5, 20, 1'b0, 1'b0);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_checks++;
        if (cfg_err_o !== 1'b1 || cfg_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_ovf: got err=%b pend=%b expected 1,0", cfg_err_o, cfg_pending_o);
        end
        while (line_start_o !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 1647 || int'(y_o) != 2 || hsync_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rej_timing: got n=%0d y=%0d hs=%b expected 1647,2,0", n, y_o, hsync_o);
        end
    endtask

    task automatic test_wrap_collision();
        int n = 0;
        load_idle(mk_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0));
        enable_i = 1'b1;
        tick();
        repeat (20) tick();
        cfg_i    = mk_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b0, 1'b0);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        while (!(int'(x_o) == 15 && int'(y_o) == 7) && n < 200) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 106 || cfg_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_reach: got n=%0d pend=%b expected 106,1", n, cfg_pending_o);
        end
        cfg_i    = mk_cfg(4, 1, 1, 2, 2, 1, 1, 1, 1'b0, 1'b0);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_checks++;
        if (frame_start_o !== 1'b1 || cfg_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_wrap: got fs=%b pend=%b expected 1,1", frame_start_o, cfg_pending_o);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start_o !== 1'b1 && n < 200);
        n_checks++;
        if (n != 60 || cfg_pending_o !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_frame_b: got len=%0d pend=%b expected 60,0", n, cfg_pending_o);
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start_o !== 1'b1 && n < 200);
        n_checks++;
        if (n != 40) begin
            n_fail++;
            $display("FAIL coll_frame_c: got len=%0d expected 40", n);
        end
    endtask

    task automatic test_underflow();
        int x0, n = 0;
        n_checks++;
        if (underflow_o !== 1'b0 || px_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_pre: got uf=%b rdy=%b expected 0,1", underflow_o, px_ready_o);
        end
        x0 = int'(x_o);
        px_valid_i = 1'b0;
        tick();
        px_valid_i = 1'b1;
        n_checks++;
        if (underflow_o !== 1'b1 || int'(x_o) != x0 + 1) begin
            n_fail++;
            $display("FAIL uf_set: got uf=%b x=%0d expected 1,%0d", underflow_o, x_o, x0 + 1);
        end
        repeat (3) tick();
        n_checks++;
        if (underflow_o !== 1'b1) begin
            n_fail++;
            $display("FAIL uf_sticky: got %b expected 1", underflow_o);
        end
        while (de_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        px_valid_i      = 1'b0;
        underflow_clr_i = 1'b1;
        tick();
        px_valid_i = 1'b1;
        n_checks++;
        if (underflow_o !== 1'b1 || n >= 50) begin
            n_fail++;
            $display("FAIL uf_set_wins: got uf=%b wait=%0d expected 1", underflow_o, n);
        end
        tick();
        underflow_clr_i = 1'b0;
        n_checks++;
        if (underflow_o !== 1'b0) begin
            n_fail++;
            $display("FAIL uf_clear: got %b expected 0", underflow_o);
        end
    endtask

    task automatic test_disable();
        int n = 0;
        load_idle(mk_cfg(302, 1, 1, 1, 101, 1, 1, 1, 1'b0, 1'b0));
        enable_i = 1'b1;
        tick();
        while (!(int'(x_o) == 300 && int'(y_o) == 100) && n < 40000) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 30800 || de_o !== 1'b1) begin
            n_fail++;
            $display("FAIL dis_reach: got n=%0d de=%b expected 30800,1", n, de_o);
        end
        enable_i = 1'b0;
        tick();
        n_checks++;
        if (de_o !== 1'b0 || hsync_o !== 1'b1 || vsync_o !== 1'b1 ||
            int'(x_o) != 0 || int'(y_o) != 0) begin
            n_fail++;
            $display("FAIL dis_idle: got de=%b hs=%b vs=%b (%0d,%0d) expected 0,1,1 (0,0)",
                     de_o, hsync_o, vsync_o, x_o, y_o);
        end
        n_checks++;
        if (line_start_o !== 1'b0 || frame_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_pulses: got ls=%b fs=%b expected 0,0", line_start_o, frame_start_o);
        end
        tick();
        enable_i = 1'b1;
        tick();
        n_checks++;
        if (frame_start_o !== 1'b1 || line_start_o !== 1'b1 || de_o !== 1'b1 ||
            int'(x_o) != 0 || int'(y_o) != 0) begin
            n_fail++;
            $display("FAIL reenable: got fs=%b ls=%b de=%b (%0d,%0d) expected 1,1,1 (0,0)",
                     frame_start_o, line_start_o, de_o, x_o, y_o);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        repeat (5) tick();
        cfg_i    = mk_cfg(8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1);
        cfg_we_i = 1'b1;
        tick();
        cfg_we_i = 1'b0;
        n_checks++;
        if (cfg_pending_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pend: got %b expected 1", cfg_pending_o);
        end
        rst_i = 1'b1;
        tick();
        n_checks++;
        if (cfg_pending_o !== 1'b0 || de_o !== 1'b0 || int'(x_o) != 0 || hsync_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state: got pend=%b de=%b x=%0d hs=%b expected 0,0,0,1",
                     cfg_pending_o, de_o, x_o, hsync_o);
        end
        rst_i = 1'b0;
        tick();
        do begin
            tick();
            n++;
        end while (line_start_o !== 1'b1 && n < 1000);
        n_checks++;
        if (n != 800 || hsync_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_default: got len=%0d hs=%b expected 800,1", n, hsync_o);
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_small_frame();
        test_pending_apply();
        test_reject();
        test_wrap_collision();
        test_underflow();
        test_disable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/paper_timing_ctrl.md
# paper_timing_ctrl

Video timing controller for the paper HDMI output path. It generates DE/HSync/VSync and pixel coordinates for the frame-buffer reader, TMDS encoder and serialisers. It pops pixels from the pixel-clock-domain FIFO and flags underflow. Timing parameters are runtime-programmable through a shadow register set, and new values are applied only at frame boundaries. It runs entirely in the pixel clock domain; configuration arrives already synchronised.

## Interface
Parameters:
- CntWidth, 12, width of every timing field and of the x/y counters.

Ports:
- clk_i  in  1  pixel clock.
- rst_i  in  1  reset. The block uses one clock; reset is synchronous and active-high.
- enable_i  in  1  run timing; low holds the block idle.
- cfg_we_i  in  1  one-cycle write strobe for cfg_i.
- cfg_i  in  timing_cfg_t  h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp (each CntWidth), hsync_pol, vsync_pol (1 = active-high).
- cfg_err_o  out  1  one-cycle pulse when a write is rejected.
- cfg_pending_o  out  1  a written config is waiting for the frame boundary.
- px_valid_i  in  1  pixel FIFO not empty.
- px_ready_o  out  1  pop pixel FIFO; equals de_o.
- de_o, hsync_o, vsync_o  out  1 each  video controls to the encoder.
- x_o, y_o  out  CntWidth each  current counter position.
- line_start_o, frame_start_o  out  1 each  pulses at h=0, and at h=0 with v=0.
- underflow_o  out  1  sticky underflow flag.
- underflow_clr_i  in  1  clears underflow_o.

## Operation
- Horizontal order is active, front porch, sync, back porch. htot is the sum of the four h fields; vtot is defined the same way from the v fields.
- hsync is asserted when h_active+h_fp ≤ x < h_active+h_fp+h_sync. vsync uses the same rule on y.
- de = (x < h_active) && (y < v_active).
- Asserted sync drives the pol level; deasserted sync drives ~pol.
- x wraps from htot−1 to 0 and then y increments. y wraps from vtot−1 to 0. Intermediate sums are computed at CntWidth+1 bits.
- Config write:
  - A write is rejected if h_active, h_sync, v_active or v_sync is 0, or if htot or vtot overflows CntWidth.
  - A rejected write pulses cfg_err_o and leaves the pending register unchanged.
  - fp and bp may be 0.
  - A legal write loads the pending register and sets cfg_pending_o. A later write overwrites the pending register.
- Config apply:
  - While enabled, pending is copied to active on the cycle the counters wrap from (htot−1, vtot−1) to (0,0).
  - While disabled, pending is applied on the cycle after the write.
  - cfg_pending_o clears on apply.
  - If a write and a wrap occur in the same cycle, the pre-write pending contents are applied. The new write remains pending with cfg_pending_o = 1.
- enable_i low:
  - Next cycle: x=y=0, de_o=0, syncs inactive, pulses 0.
  - Pending config still applies.
- enable_i rising: the first enabled cycle shows (0,0) with de_o=1 and frame_start_o=1.
- Underflow:
  - underflow_o sets on any cycle with de_o=1 and px_valid_i=0.
  - underflow_clr_i clears it; if set and clear coincide, set wins.
  - Underflow does not alter timing.
- Reset values:
  - Active and pending config: 640x480 timing (h 640/16/96/48, v 480/10/2/33, both polarities 0).
  - cfg_pending_o=0, x=y=0, all pulses 0, de_o=0, hsync_o=vsync_o=1 (inactive, active-low), underflow_o=0.
  - enable_i is ignored while rst_i=1.

## Timing
- All outputs are registered.
- x_o/y_o and every control output refer to the same pixel. Zero skew between de_o, syncs and coordinates.
- Counter advance: one pixel per clk_i while enabled. Frame period is htot·vtot cycles.
- cfg_err_o: one cycle after cfg_we_i.
- cfg_pending_o: rises the cycle after a legal write.
- New timing: takes effect from the first (0,0) pixel output after apply.
- rst_i asserted mid-frame: all state returns to reset values on the next edge; any pending config is discarded.

## Structure
- Package paper_timing_pkg holds:
  - timing_cfg_t (packed struct of the fields above);
  - constant TimingCfgDefault (the 640x480 values);
  - function cfg_legal().
- Natural sub-module: paper_timing_axis, instantiated twice (H and V).
  - Inputs: one axis counter value and its four fields.
  - Outputs: active, sync and last flags, plus the wrapped next value given an advance input.

## Test plan
- Reset then enable with the default config:
  - de_o high for 640 consecutive cycles per line;
  - hsync_o low for x=656..751;
  - vsync_o low for y=490..491;
  - frame_start_o period exactly 420000 cycles.
- Mid-frame write of 1280x720 (h 1280/110/40/220, v 720/5/5/20, pol 1):
  - cfg_pending_o=1 until wrap;
  - old timing continues to (799,524);
  - next frame has htot 1650 and hsync_o high for x=1390..1429.
- Write with h_sync=0 → cfg_err_o pulse, cfg_pending_o stays 0, timing unchanged.
- Write landing exactly on the wrap cycle → previous pending config applied, new config applied at the following wrap.
- Hold px_valid_i=0 for one active pixel:
  - underflow_o=1 and stays set;
  - asserting underflow_clr_i together with another starved pixel leaves it set;
  - clearing alone clears it.
- Drop enable_i at x=300,y=100:
  - next cycle de_o=0, syncs inactive, x=y=0;
  - re-enable → frame_start_o on the first enabled cycle.
